// File: rtl/pointwise_mac_if.sv
// Stream interface for pointwise_mac: input beats from the NTT, accumulated
// output beats to the INTT, plus busy back-pressure and the range-error flag.
interface pointwise_mac_if;
    logic               i_valid;
    logic signed [31:0] i_a;
    logic signed [31:0] i_b;
    logic               i_last_poly;
    logic               o_busy;
    logic               o_valid;
    logic signed [31:0] o_data;
    logic               o_err;

    // Upstream / bench side
    modport master (
        output i_valid, i_a, i_b, i_last_poly,
        input  o_busy, o_valid, o_data, o_err
    );

    // pointwise_mac side
    modport slave (
        input  i_valid, i_a, i_b, i_last_poly,
        output o_busy, o_valid, o_data, o_err
    );
endinterface

// File: rtl/pointwise_mac.sv
// pointwise_mac: accumulates a[k]*b[k] mod Q over one or more polynomials into
// an N-entry buffer through a 3-stage pipeline (multiply, Barrett reduce,
// accumulate), then streams acc[0..N-1] out in N consecutive cycles.
// Optional macro PMAC_RANGE_CHECK_EN adds a sticky o_err for inputs outside
// (-Q, Q); without it o_err is tied low.
module pointwise_mac #(
    parameter int unsigned Q = 8380417,
    parameter int unsigned N = 256
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pointwise_mac_if.slave bus
);
    localparam int unsigned      QW       = $clog2(Q);
    localparam int unsigned      PW       = 2 * QW;
    localparam int unsigned      MW       = QW + 1;
    localparam int unsigned      IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [QW-1:0]    QV       = QW'(Q);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
    localparam longint unsigned  MU       = (64'd1 << PW) / 64'(Q);
    localparam logic [MW-1:0]    MUV      = MW'(MU);
    localparam logic signed [31:0] QS     = $signed(32'(Q));

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   drain_idx_q, drain_idx_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            ovalid_q, ovalid_d;
    logic [31:0]     odata_q, odata_d;
    logic            accept, last_cur, final_beat;

    logic            s1_vld_q, s1_ovw_q, s1_fin_q;
    logic [IW-1:0]   s1_idx_q;
    logic [PW-1:0]   s1_prod_q;
    logic            s2_vld_q, s2_ovw_q, s2_fin_q;
    logic [IW-1:0]   s2_idx_q;
    logic [QW-1:0]   s2_red_q;
    logic [QW-1:0]   acc_mem_q [N];

    logic signed [31:0] a_adj, b_adj;
    logic [QW-1:0]   a_n, b_n;
    logic [PW+MW-1:0] pm;
    logic [MW-1:0]   qhat;
    logic [PW-1:0]   r0;
    logic [QW-1:0]   red;
    logic [QW:0]     sum;
    logic [QW-1:0]   acc_new;

    // Beat acceptance, beat index and per-polynomial flags
    always_comb begin
        accept     = bus.i_valid && !busy_q && (state_q != DRAIN);
        last_cur   = (idx_q == '0) ? bus.i_last_poly : last_q;
        final_beat = accept && (idx_q == LAST_IDX) && last_cur;
        idx_d      = idx_q;
        last_d     = last_q;
        first_d    = first_q;
        if (accept) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (idx_q == '0) last_d = bus.i_last_poly;
            // Next polynomial overwrites only if this one closed the accumulation
            if (idx_q == LAST_IDX) first_d = last_cur;
        end
    end

    // S1 operands: fold negative inputs into [0, Q)
    always_comb begin
        a_adj = bus.i_a[31] ? bus.i_a + QS : bus.i_a;
        b_adj = bus.i_b[31] ? bus.i_b + QS : bus.i_b;
        a_n   = QW'(a_adj);
        b_n   = QW'(b_adj);
    end

    // S2 Barrett reduction; mu = floor(2^PW/Q) leaves the remainder below 2Q
    always_comb begin
        pm   = (PW+MW)'(s1_prod_q) * (PW+MW)'(MUV);
        qhat = MW'(pm >> PW);
        r0   = s1_prod_q - PW'(qhat) * PW'(QV);
        red  = (r0 >= PW'(Q)) ? QW'(r0 - PW'(Q)) : QW'(r0);
    end

    // S3 accumulate into the buffer entry, or overwrite on the first polynomial
    always_comb begin
        sum     = s2_ovw_q ? {1'b0, s2_red_q}
                           : {1'b0, acc_mem_q[s2_idx_q]} + {1'b0, s2_red_q};
        acc_new = (sum >= {1'b0, QV}) ? QW'(sum - {1'b0, QV}) : QW'(sum);
    end

    // FSM next state, drain sequencing and output beat generation
    always_comb begin
        state_d     = state_q;
        drain_idx_d = drain_idx_q;
        ovalid_d    = 1'b0;
        odata_d     = '0;
        busy_d      = busy_q;
        // busy spans final accept through the cycle carrying acc[N-1]
        if (final_beat)                   busy_d = 1'b1;
        else if (state_q == IDLE && ovalid_q) busy_d = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (s2_vld_q && s2_fin_q) state_d = DRAIN;
            DRAIN: begin
                ovalid_d    = 1'b1;
                odata_d     = 32'(acc_mem_q[drain_idx_q]);
                drain_idx_d = (drain_idx_q == LAST_IDX) ? '0 : drain_idx_q + 1'b1;
                if (drain_idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and pipeline valid bits, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_idx_q <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovalid_q    <= 1'b0;
            odata_q     <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_idx_q <= drain_idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            ovalid_q    <= ovalid_d;
            odata_q     <= odata_d;
            s1_vld_q    <= accept;
            s2_vld_q    <= s1_vld_q;
        end
    end

    // Datapath registers and buffer write; qualified by the valid bits above
    always_ff @(posedge i_clk) begin
        s1_prod_q <= PW'(a_n) * PW'(b_n);
        s1_idx_q  <= idx_q;
        s1_ovw_q  <= first_q;
        s1_fin_q  <= final_beat;
        s2_red_q  <= red;
        s2_idx_q  <= s1_idx_q;
        s2_ovw_q  <= s1_ovw_q;
        s2_fin_q  <= s1_fin_q;
        if (s2_vld_q) acc_mem_q[s2_idx_q] <= acc_new;
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_valid = ovalid_q;
    assign bus.o_data  = odata_q;

`ifdef PMAC_RANGE_CHECK_EN
    logic err_q;

    // Sticky flag for any accepted operand outside (-Q, Q)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (accept && (bus.i_a >= QS || bus.i_a <= -QS ||
                                bus.i_b >= QS || bus.i_b <= -QS)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_pointwise_mac.sv
// Directed bench for pointwise_mac: single/multi-polynomial accumulation,
// modular wrap, gapped and back-to-back input, reset abort, input during
// drain and the range-error flag.
module tb_pointwise_mac;
    localparam int unsigned Q = 8380417;
    localparam int unsigned N = 256;

`ifdef PMAC_RANGE_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ov_count = 0;
    int   a_vec [N];
    int   b_vec [N];
    int   got [N];

    pointwise_mac_if bus ();

    pointwise_mac #(.Q(Q), .N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_valid === 1'b1) ov_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.i_valid = 1'b0; bus.i_a = 0; bus.i_b = 0; bus.i_last_poly = 1'b0;
    endtask

    // Feeds nbeats beats from a_vec/b_vec; returns #1 after the edge that
    // accepts the final beat. i_last_poly is inverted on beats other than 0.
    task automatic send_poly(input bit last, input bit gapped, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            @(posedge clk); #1;
            if (gapped && k > 0) begin
                bus.i_valid = 1'b0; bus.i_last_poly = ~last;
                @(posedge clk); #1;
            end
            bus.i_valid = 1'b1; bus.i_a = a_vec[k]; bus.i_b = b_vec[k];
            bus.i_last_poly = (k == 0) ? last : ~last;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_last_poly = 1'b0;
    endtask

    // Records latency (negedges after final accept), valid count over N beats,
    // busy on the first cycle, and nonzero o_data while idle. Ends on the
    // negedge of the last sampled beat.
    task automatic capture(output int lat, output int nvalid, output bit busy1, output int nz_idle);
        lat = -1; nvalid = 0; busy1 = 1'b0; nz_idle = 0;
        for (int j = 0; j < N; j++) got[j] = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = bus.o_busy;
            if (bus.o_valid === 1'b1) begin lat = k; break; end
            if (bus.o_data !== 0) nz_idle++;
        end
        if (lat < 0) return;
        got[0] = bus.o_data; nvalid = 1;
        for (int j = 1; j < N; j++) begin
            @(negedge clk);
            got[j] = bus.o_data;
            if (bus.o_valid === 1'b1) nvalid++;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_data !== 0) begin failures++; $display("FAIL reset_data got=%0d exp=0", bus.o_data); end
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int lat, nv, nz; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = k; b_vec[k] = 2; end
        send_poly(1'b1, 1'b0, N);
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", lat); end
        checks++; if (nv !== N) begin failures++; $display("FAIL single_contig got=%0d exp=%0d", nv, N); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", b1); end
        checks++; if (nz !== 0) begin failures++; $display("FAIL single_idle_data got=%0d exp=0", nz); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== 2 * k) begin failures++; $display("FAIL single_data[%0d] got=%0d exp=%0d", k, got[k], 2 * k); end
        end
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL single_end_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_end_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_data !== 0) begin failures++; $display("FAIL single_end_data got=%0d exp=0", bus.o_data); end
    endtask

    task automatic test_wrap();
        int lat, nv, nz; bit b1;
        int exp_v [2];
        exp_v[0] = 1; exp_v[1] = 8380412;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                a_vec[k] = (r == 0) ? int'(Q) - 1 : -1;
                b_vec[k] = (r == 0) ? int'(Q) - 1 : 5;
            end
            send_poly(1'b1, 1'b0, N);
            capture(lat, nv, b1, nz);
            checks++; if (lat !== 4) begin failures++; $display("FAIL wrap%0d_latency got=%0d exp=4", r, lat); end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (got[k] !== exp_v[r]) begin failures++; $display("FAIL wrap%0d_data[%0d] got=%0d exp=%0d", r, k, got[k], exp_v[r]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_two_poly_gapped();
        int lat, nv, nz, ov0; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = k; b_vec[k] = 1; end
        ov0 = ov_count;
        send_poly(1'b0, 1'b1, N);
        send_poly(1'b1, 1'b1, N);
        checks++; if (ov_count !== ov0) begin failures++; $display("FAIL gapped_early_valid got=%0d exp=%0d", ov_count, ov0); end
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 4) begin failures++; $display("FAIL gapped_latency got=%0d exp=4", lat); end
        checks++; if (nv !== N) begin failures++; $display("FAIL gapped_contig got=%0d exp=%0d", nv, N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== 2 * k) begin failures++; $display("FAIL gapped_data[%0d] got=%0d exp=%0d", k, got[k], 2 * k); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, nv, nz; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = int'(Q) - 1; b_vec[k] = 1; end
        send_poly(1'b0, 1'b0, N);
        for (int k = 0; k < N; k++) a_vec[k] = 2;
        send_poly(1'b1, 1'b0, N);
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== 1) begin failures++; $display("FAIL b2b_data[%0d] got=%0d exp=1", k, got[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, nv, nz, ov0; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = k + 1; b_vec[k] = 9; end
        ov0 = ov_count;
        send_poly(1'b1, 1'b0, 101);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.o_busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin a_vec[k] = 3; b_vec[k] = 4; end
        send_poly(1'b1, 1'b0, N);
        checks++; if (ov_count !== ov0) begin failures++; $display("FAIL abort_stray_valid got=%0d exp=%0d", ov_count, ov0); end
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 4) begin failures++; $display("FAIL abort_latency got=%0d exp=4", lat); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== 12) begin failures++; $display("FAIL abort_data[%0d] got=%0d exp=12", k, got[k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_valid_during_drain();
        int lat, nv, nz; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = k; b_vec[k] = 3; end
        send_poly(1'b1, 1'b0, N);
        bus.i_valid = 1'b1; bus.i_a = 7; bus.i_b = 1; bus.i_last_poly = 1'b1;
        capture(lat, nv, b1, nz);
        bus.i_valid = 1'b0; bus.i_last_poly = 1'b0;
        checks++; if (lat !== 4) begin failures++; $display("FAIL drain_latency got=%0d exp=4", lat); end
        checks++; if (nv !== N) begin failures++; $display("FAIL drain_contig got=%0d exp=%0d", nv, N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== 3 * k) begin failures++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", k, got[k], 3 * k); end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin a_vec[k] = k; b_vec[k] = 1; end
        send_poly(1'b1, 1'b0, N);
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 4) begin failures++; $display("FAIL after_drain_latency got=%0d exp=4", lat); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got[k] !== k) begin failures++; $display("FAIL after_drain_data[%0d] got=%0d exp=%0d", k, got[k], k); end
        end
        @(negedge clk);
    endtask

    task automatic test_err();
        int lat, nv, nz; bit b1;
        for (int k = 0; k < N; k++) begin a_vec[k] = 0; b_vec[k] = 1; end
        a_vec[N-1] = int'(Q);
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", bus.o_err); end
        send_poly(1'b1, 1'b0, N);
        @(negedge clk);
        checks++; if (bus.o_err !== EXP_ERR) begin failures++; $display("FAIL err_next_cycle got=%b exp=%b", bus.o_err, EXP_ERR); end
        capture(lat, nv, b1, nz);
        checks++; if (lat !== 3) begin failures++; $display("FAIL err_latency got=%0d exp=3", lat); end
        @(negedge clk);
        checks++; if (bus.o_err !== EXP_ERR) begin failures++; $display("FAIL err_held got=%b exp=%b", bus.o_err, EXP_ERR); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", bus.o_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_two_poly_gapped();
        test_back_to_back();
        test_reset_abort();
        test_valid_during_drain();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pointwise_mac.md
POINTWISE_MAC -- requirements
Module: pointwise_mac

Interface
REQ-001 Parameter: Q, default 8380417, the ML-DSA modulus; all arithmetic is mod Q.
REQ-002 Parameter: N, default 256, coefficients per polynomial.
REQ-003 Port: i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port: i_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_valid  in  1  input beat strobe, driven by the upstream ntt o_valid.
REQ-006 Port: i_a  in  32 signed  NTT-domain coefficient from ntt o_data, range (-Q, Q).
REQ-007 Port: i_b  in  32 signed  second-operand coefficient, same beat as i_a, range (-Q, Q).
REQ-008 Port: i_last_poly  in  1  marks the final polynomial of an accumulation; sampled on beat 0 only.
REQ-009 Port: o_busy  out  1  high while draining; upstream must hold i_valid low.
REQ-010 Port: o_valid  out  1  output beat strobe, driving the downstream intt i_ready.
REQ-011 Port: o_data  out  32 signed  accumulated coefficient, canonical [0, Q), zero-extended.
REQ-012 Port: o_err  out  1  sticky input-range error flag (see Configuration).

Function
REQ-013 Computes acc[k] = sum over polys of a[k]*b[k] mod Q, k = 0..N-1, then streams acc[0..N-1] out.
REQ-014 FSM states and transitions:
  - IDLE -> ACCUM on the first i_valid.
  - ACCUM -> DRAIN once the last beat of the last polynomial has left the pipeline.
  - DRAIN -> IDLE after beat N-1 is emitted.
REQ-015 Beat index counter: 0..N-1, advances only on accepted beats (i_valid high, state IDLE or ACCUM), wraps N-1 -> 0; gaps in i_valid are legal.
REQ-016 Accepted beat with index 0 latches i_last_poly as the is-last flag for that polynomial.
REQ-017 First polynomial of an accumulation overwrites acc[k]; later polynomials add to acc[k].
REQ-018 Normalisation: negative inputs get +Q before multiplication; the product (<=46 bits) is reduced exactly to [0, Q).
REQ-019 Accumulation: acc + p; subtract Q if the sum >= Q.
REQ-020 Pipeline, 3 registered stages:
  - S1: normalise and multiply.
  - S2: reduce.
  - S3: accumulate and write the 23-bit x N buffer.
  - Accepts one beat per cycle with no stalls.
REQ-021 Back-to-back polynomials: no read-after-write hazard, since in-flight indices always differ; when index 0 of poly n+1 directly follows index N-1 of poly n, no bubble is required.
REQ-022 Latency: first o_valid is exactly 4 cycles after the cycle in which the final beat is accepted; then o_valid stays high for N consecutive cycles with o_data = acc[0], acc[1], ... acc[N-1].
REQ-023 o_busy is high from the cycle after the final beat is accepted through the last DRAIN beat.
REQ-024 i_valid while o_busy is high is ignored and does not change the buffer or counters.
REQ-025 o_data is 0 whenever o_valid is low.

Reset
REQ-026 i_rst clears the following immediately, independent of the clock: FSM to IDLE, beat counter, pipeline valid bits, o_valid, o_busy, o_data, o_err.
REQ-027 Buffer contents are not reset; the first polynomial after reset overwrites every entry, so no stale data reaches the output.
REQ-028 Reset asserted mid-ACCUM or mid-DRAIN aborts the operation; no o_valid is produced for the aborted accumulation.

Configuration
REQ-029 Macro PMAC_RANGE_CHECK_EN, when defined:
  - Sets o_err on any accepted beat with i_a or i_b outside (-Q, Q).
  - o_err then holds until reset.
  - The datapath result is unspecified for that beat.
REQ-030 Macro undefined: no range-check logic; o_err is tied to 0.

Verification
REQ-031 Single poly, a[k]=k, b[k]=2, last on beat 0 -> out[k]=2k; first o_valid 4 cycles after beat 255; 256 contiguous valid cycles.
REQ-032 Wrap: a=Q-1, b=Q-1 on all k, single poly -> every output = 1; a=-1, b=5 -> every output = 8380412.
REQ-033 Two polys, a[k]=k, b=1 each, last on poly 1, i_valid toggling every other cycle -> out[k]=2k; poly 0 with a=Q-1, b=1 plus poly 1 with a=2, b=1 -> out = 1.
REQ-034 Reset at ACCUM beat 100, then a fresh single poly a=3, b=4 -> all 256 outputs = 12, no o_valid before that run.
REQ-035 i_valid held high during DRAIN with a=7 -> output stream unchanged; the next accumulation is unaffected.
REQ-036 With PMAC_RANGE_CHECK_EN, one beat a=Q -> o_err=1 next cycle, held until reset; without the macro -> o_err stays 0.
